// File: rtl/phase_sequencer.sv
// phase_sequencer: registered 8-phase instruction sequencer for the VeriRISC core.
// Decides run / memory-stall / single-step / halt, and counts retired instructions.
// Optional watchdog on memory stalls: define PHASE_SEQ_WATCHDOG_EN to build it in.
//
// Ports:
//   clk, rst_          clock (rising edge) and asynchronous active-low reset
//   run                one-cycle start/resume pulse (IDLE, STEP_HOLD, HALTED)
//   step_mode, step    stop at every instruction boundary / release one instruction
//   halt               controller halt, honoured only when phase 4 advances
//   mem_req, mem_ready memory handshake; a request without ready inserts wait states
//   phase              registered phase fed to the controller
//   running, stalled   state flags (RUN or WAIT / WAIT only)
//   instr_done         one-cycle pulse after each 7->0 phase wrap
//   instr_count        retired instructions, wraps
//   timeout_err        sticky watchdog trip flag (tied 0 without the watchdog)
module phase_sequencer #(
  parameter int PHASE_WIDTH = 3,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   run,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   halt,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   running,
  output logic                   stalled,
  output logic                   instr_done,
  output logic [CNT_WIDTH-1:0]   instr_count,
  output logic                   timeout_err
);

  // The wait counter is 8 bits wide, so the stall limit must fit in it.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
    $error("phase_sequencer: MEM_TIMEOUT must be in 1..255");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  localparam logic [PHASE_WIDTH-1:0] PH_HALT = PHASE_WIDTH'(4);
  localparam logic [PHASE_WIDTH-1:0] PH_LAST = PHASE_WIDTH'(7);

  logic [2:0]             state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;

  // Result of a normal phase advance; shared by RUN and by WAIT when memory completes.
  logic [2:0]             adv_state;
  logic [PHASE_WIDTH-1:0] adv_phase;
  logic                   adv_done;
  logic [CNT_WIDTH-1:0]   adv_count;

`ifdef PHASE_SEQ_WATCHDOG_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       terr_q, terr_d;
`endif

  always_comb begin
    adv_state = S_RUN;
    adv_phase = phase_q + PHASE_WIDTH'(1);
    adv_done  = 1'b0;
    adv_count = count_q;
    if (phase_q == PH_HALT && halt) begin
      // Halt retires nothing: no pulse, count untouched.
      adv_state = S_HALT;
      adv_phase = '0;
    end else if (phase_q == PH_LAST) begin
      adv_phase = '0;
      adv_done  = 1'b1;
      adv_count = count_q + CNT_WIDTH'(1);
      adv_state = step_mode ? S_HOLD : S_RUN;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    count_d = count_q;
`ifdef PHASE_SEQ_WATCHDOG_EN
    wait_cnt_d = wait_cnt_q;
    terr_d     = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (run) state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          // Stall takes priority over everything, including a phase-4 halt.
          state_d = S_WAIT;
`ifdef PHASE_SEQ_WATCHDOG_EN
          wait_cnt_d = 8'd1;
`endif
        end else begin
          state_d = adv_state;
          phase_d = adv_phase;
          done_d  = adv_done;
          count_d = adv_count;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = adv_state;
          phase_d = adv_phase;
          done_d  = adv_done;
          count_d = adv_count;
`ifdef PHASE_SEQ_WATCHDOG_EN
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_LIM) begin
          state_d    = S_HALT;
          phase_d    = '0;
          terr_d     = 1'b1;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        end
      end
      S_HOLD: begin
        phase_d = '0;
        if (step || run) state_d = S_RUN;
      end
      S_HALT: begin
        phase_d = '0;
        if (run) begin
          state_d = S_RUN;
`ifdef PHASE_SEQ_WATCHDOG_EN
          terr_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

`ifdef PHASE_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wait_cnt_q <= 8'd0;
      terr_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      terr_q     <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign phase       = phase_q;
  assign running     = (state_q == S_RUN) || (state_q == S_WAIT);
  assign stalled     = (state_q == S_WAIT);
  assign instr_done  = done_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic run = 1'b0, step_mode = 1'b0, step = 1'b0, halt = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b1;
  logic [2:0]  dut_phase;
  logic        dut_running, dut_stalled, dut_done, dut_terr;
  logic [15:0] dut_count;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  phase_sequencer #(.PHASE_WIDTH(3), .CNT_WIDTH(16), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_(rst_), .run(run), .step_mode(step_mode), .step(step),
    .halt(halt), .mem_req(mem_req), .mem_ready(mem_ready),
    .phase(dut_phase), .running(dut_running), .stalled(dut_stalled),
    .instr_done(dut_done), .instr_count(dut_count), .timeout_err(dut_terr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_WAIT, M_HOLD, M_HALT} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_phase = 0, m_count = 0, m_waits = 0;
  bit    m_done = 1'b0, m_terr = 1'b0;

  // One instruction phase completes.
  function void m_advance();
    if (m_phase == 4 && halt) begin
      m_mode  = M_HALT;
      m_phase = 0;
    end else if (m_phase == 7) begin
      m_phase = 0;
      m_done  = 1'b1;
      m_count = (m_count + 1) % 65536;
      m_mode  = step_mode ? M_HOLD : M_RUN;
    end else begin
      m_phase = m_phase + 1;
      m_mode  = M_RUN;
    end
  endfunction

  always @(posedge clk or negedge rst_) begin : model
    mode_t cur;
    if (!rst_) begin
      m_mode = M_IDLE; m_phase = 0; m_count = 0; m_waits = 0;
      m_done = 1'b0;   m_terr = 1'b0;
    end else begin
      cur    = m_mode;
      m_done = 1'b0;
      if (cur == M_IDLE || cur == M_HOLD || cur == M_HALT) begin
        m_phase = 0;
        if (run || (cur == M_HOLD && step)) m_mode = M_RUN;
        if (cur == M_HALT && run) m_terr = 1'b0;
      end else if (cur == M_RUN) begin
        if (mem_req && !mem_ready) begin
          m_mode  = M_WAIT;
          m_waits = 1;
        end else m_advance();
      end else begin
        if (mem_ready) m_advance();
`ifdef PHASE_SEQ_WATCHDOG_EN
        else if (m_waits == TIMEOUT) begin
          m_mode = M_HALT; m_phase = 0; m_terr = 1'b1;
        end
`endif
        else m_waits = m_waits + 1;
      end
    end
  end

  // Single compare process: every cycle while out of reset.
  always @(negedge clk) begin
    if (check_en && rst_ === 1'b1) begin
      chk("phase",       dut_phase,   m_phase);
      chk("running",     dut_running, (m_mode == M_RUN || m_mode == M_WAIT));
      chk("stalled",     dut_stalled, (m_mode == M_WAIT));
      chk("instr_done",  dut_done,    m_done);
      chk("instr_count", dut_count,   m_count);
      chk("timeout_err", dut_terr,    m_terr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1; tick(); run = 1'b0;
  endtask

  task automatic wait_run_phase(input int p, input int budget);
    int n = 0;
    while (!(dut_running === 1'b1 && dut_phase === 3'(p)) && n < budget) begin
      tick(); n++;
    end
    chk("reach_phase", dut_phase, p);
    chk("reach_running", dut_running, 1);
  endtask

  task automatic wait_stop(input int budget);
    int n = 0;
    while (dut_running !== 1'b0 && n < budget) begin
      tick(); n++;
    end
    chk("stop_running", dut_running, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"},   dut_phase, 0);
    chk({tag, "_running"}, dut_running, 0);
    chk({tag, "_stalled"}, dut_stalled, 0);
    chk({tag, "_done"},    dut_done, 0);
    chk({tag, "_count"},   dut_count, 0);
    chk({tag, "_terr"},    dut_terr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int cycles, n_stall, saved, stuck;

    // ---- reset ----
    #2 rst_ = 1'b0;
    #20;
    chk_reset_vals("reset");
    tick();
    rst_ = 1'b1;
    check_en = 1'b1;
    repeat (3) tick();
    chk("idle_phase", dut_phase, 0);

    // ---- free run: phase 0 in the cycle after run, 3 instructions in 24 cycles ----
    pulse_run();
    chk("run_running", dut_running, 1);
    chk("run_phase0", dut_phase, 0);
    repeat (24) tick();
    chk("run24_count", dut_count, 3);
    chk("run24_phase", dut_phase, 0);
    chk("run24_done", dut_done, 1);

    // ---- 3-cycle memory stall at phase 1 ----
    tick();
    chk("stall_start_phase", dut_phase, 1);
    mem_req = 1'b1; mem_ready = 1'b0;
    cycles = 1; n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); cycles++;
      if (dut_stalled === 1'b1) begin
        n_stall++;
        chk("stall_hold_phase", dut_phase, 1);
        if (n_stall == 3) mem_ready = 1'b1;
      end else mem_req = 1'b0;
      if (dut_done === 1'b1) break;
    end
    mem_req = 1'b0; mem_ready = 1'b1;
    chk("stall_cycles", n_stall, 3);
    chk("stall_instr_len", cycles, 11);

    // ---- halt: ignored in phase 2, honoured in phase 4 ----
    wait_run_phase(2, 20);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_p2_phase", dut_phase, 3);
    chk("halt_p2_running", dut_running, 1);
    wait_run_phase(4, 20);
    saved = dut_count;
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_phase", dut_phase, 0);
    chk("halt_running", dut_running, 0);
    chk("halt_count", dut_count, saved);
    repeat (3) tick();
    chk("halted_stays", dut_running, 0);
    pulse_run();
    chk("restart_phase", dut_phase, 0);
    chk("restart_running", dut_running, 1);

    // ---- single step ----
    step_mode = 1'b1;
    wait_run_phase(3, 20);
    step = 1'b1; tick(); step = 1'b0;
    chk("step_in_run_phase", dut_phase, 4);
    wait_stop(20);
    chk("hold_phase", dut_phase, 0);
    saved = dut_count;
    for (int k = 0; k < 2; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      for (int j = 0; j < 8; j++) begin
        chk("step_phase", dut_phase, j);
        chk("step_running", dut_running, 1);
        tick();
      end
      chk("step_stopped", dut_running, 0);
      chk("step_count", dut_count, (saved + k + 1) & 16'hFFFF);
    end
    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    chk("run_and_step", dut_running, 1);
    step_mode = 1'b0;

    // ---- memory stuck at phase 1 ----
    wait_run_phase(1, 20);
    mem_req = 1'b1; mem_ready = 1'b0;
`ifdef PHASE_SEQ_WATCHDOG_EN
    repeat (4) tick();
    chk("wd_still_waiting", dut_stalled, 1);
    tick();
    chk("wd_terr", dut_terr, 1);
    chk("wd_running", dut_running, 0);
    chk("wd_phase", dut_phase, 0);
    mem_req = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    chk("wd_terr_sticky", dut_terr, 1);
    pulse_run();
    chk("wd_terr_cleared", dut_terr, 0);
    chk("wd_restart", dut_running, 1);
`else
    repeat (100) tick();
    chk("nowd_stalled", dut_stalled, 1);
    chk("nowd_phase", dut_phase, 1);
    chk("nowd_terr", dut_terr, 0);
    mem_ready = 1'b1;
    tick();
    mem_req = 1'b0;
    chk("nowd_release_phase", dut_phase, 2);
`endif

    // ---- randomized traffic ----
    stuck = 0;
    for (int i = 0; i < 1500; i++) begin
      run  = ($urandom_range(0, 15) == 0);
      step = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0) step_mode = ~step_mode;
      mem_req = ($urandom_range(0, 2) == 0);
      if (stuck == 0 && $urandom_range(0, 199) == 0) stuck = 10;
      if (stuck > 0) begin
        mem_ready = 1'b0;
        stuck--;
      end else mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    run = 1'b0; step = 1'b0; halt = 1'b0; step_mode = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;

    // ---- asynchronous reset mid-WAIT at phase 5 with count 7 ----
    rst_ = 1'b0; tick(); rst_ = 1'b1;
    pulse_run();
    repeat (61) tick();
    chk("pre_rst_count", dut_count, 7);
    chk("pre_rst_phase", dut_phase, 5);
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (2) tick();
    chk("pre_rst_stalled", dut_stalled, 1);
    #2 rst_ = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    tick();
    rst_ = 1'b1; mem_req = 1'b0; mem_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_idle", dut_running, 0);
    chk("post_rst_phase", dut_phase, 0);
    pulse_run();
    chk("post_rst_run", dut_running, 1);
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Registered phase sequencer for the VeriRISC core. It generates the 3-bit instruction phase that drives the combinational controller and decides when the machine runs, stalls, single-steps or halts. It inserts wait states while memory is not ready and counts retired instructions. It sits between the top-level run/debug controls, the memory ready signal and the controller's `phase` input.

## Interface
- `PHASE_WIDTH`, 3: width of `phase`. The 8-phase cycle assumes 3.
- `CNT_WIDTH`, 16: width of the retired-instruction counter.
- `MEM_TIMEOUT`, 15: maximum consecutive wait-state cycles before a watchdog trip. Range 1..255.
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `run` in 1: one-cycle start/resume pulse.
- `step_mode` in 1: level input. 1 = stop at every instruction boundary.
- `step` in 1: one-cycle pulse that executes one instruction while held at a boundary.
- `halt` in 1: controller halt output, qualified internally by phase 4.
- `mem_req` in 1: controller requests memory this phase (`rd | wr`).
- `mem_ready` in 1: memory completes the access this cycle.
- `phase` out PHASE_WIDTH: current phase, registered.
- `running` out 1: 1 in RUN or WAIT.
- `stalled` out 1: 1 in WAIT.
- `instr_done` out 1: one-cycle pulse on the edge where phase advances 7→0.
- `instr_count` out CNT_WIDTH: retired instructions. Wraps modulo 2^CNT_WIDTH.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- States:
  - IDLE: post-reset.
  - RUN: phases advancing.
  - WAIT: memory stall, phase held.
  - STEP_HOLD: stopped at a boundary in step mode.
  - HALTED: stopped after HALT or timeout.
- IDLE: `phase`=0. When `run`=1 → RUN.
- RUN, with `mem_req`=1 and `mem_ready`=0 → WAIT. Phase is held and the wait counter is loaded with 1.
- RUN, otherwise (normal advance):
  - Phase 4 with `halt`=1 → HALTED, `phase`=0. No `instr_done` pulse, count unchanged.
  - Phase 7 → `phase`=0, `instr_done`=1, `instr_count`+1. If `step_mode`=1 the state becomes STEP_HOLD, otherwise it stays RUN.
  - Any other phase → `phase`+1.
- WAIT: when `mem_ready`=1, the state goes back to RUN and phase advances on the same edge using the RUN advance rules. Otherwise phase is held and the wait counter increments.
- STEP_HOLD: `phase`=0. When `step`=1 or `run`=1 → RUN.
- HALTED: `phase`=0. When `run`=1 → RUN and `timeout_err` clears.
- Ignored inputs:
  - `run` in RUN or WAIT.
  - `step` outside STEP_HOLD.
  - `halt` outside phase 4.
- Simultaneous events:
  - A stall beats `halt`: `halt` is evaluated only on the edge where phase 4 advances.
  - `run` and `step` together in STEP_HOLD → RUN.
  - `step_mode` is sampled only at the 7→0 edge.

## Timing
- Reset values: state IDLE, `phase`=0, `running`=0, `stalled`=0, `instr_done`=0, `instr_count`=0, `timeout_err`=0, wait counter 0.
- Reset asserted mid-operation forces these values immediately, with no clock required.
- `run` sampled at edge N → RUN after N. Phase 0 is visible during cycle N+1, phase 1 after edge N+1.
- An unstalled instruction takes exactly 8 cycles. Each wait cycle adds 1 cycle.
- `instr_done` is registered and high for the cycle following the 7→0 edge.
- `instr_count` updates on that same edge.
- A halt sampled at the end of phase 4 gives `running`=0 and `phase`=0 on the next cycle.

## Configuration
- `PHASE_SEQ_WATCHDOG_EN` defined:
  - In WAIT, if the wait counter equals `MEM_TIMEOUT` and `mem_ready`=0 at an edge → HALTED, `phase`=0, `timeout_err`=1.
  - `timeout_err` stays set until reset or `run` in HALTED.
- `PHASE_SEQ_WATCHDOG_EN` undefined:
  - The wait counter and timeout logic are absent.
  - `timeout_err` is tied 0.
  - WAIT persists indefinitely until `mem_ready`=1.

## Test plan
- Reset, `run` pulse, `mem_ready`=1 constant, `halt`=0:
  - Phase sequence 0..7 repeats with one phase per cycle.
  - `instr_done` pulses every 8 cycles.
  - `instr_count`=3 after 24 cycles in RUN.
- `mem_req`=1 in phase 1 with `mem_ready` low for 3 cycles:
  - `phase` holds at 1 and `stalled`=1 for 3 cycles.
  - The instruction takes 11 cycles.
- `halt`=1 during phase 4:
  - Next cycle: `phase`=0, `running`=0, count unchanged.
  - `run` restarts at phase 0.
  - `halt`=1 in phase 2 has no effect.
- `step_mode`=1:
  - The sequencer stops in STEP_HOLD at `phase`=0 after one instruction.
  - Each `step` pulse executes exactly 8 phases and increments the count by 1.
  - `step` during RUN is ignored.
- Watchdog build, `MEM_TIMEOUT`=4, `mem_ready` stuck 0 at phase 1:
  - After 4 wait cycles: `timeout_err`=1, HALTED, `phase`=0.
  - `run` clears `timeout_err`.
  - Non-watchdog build: the sequencer stays in WAIT for 100 cycles.
- Assert `rst_` low mid-WAIT at phase 5, `instr_count`=7:
  - All outputs return to reset values asynchronously.
  - After release the sequencer stays in IDLE until `run`.
